ldpc_iter_ctrl: RTL



---
 rtl/ldpc_iter_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: iteration controller and LLR/shift-matrix buffer for the
// QC-LDPC decoder array. Loads one block-column of LLRs per accepted beat,
// runs the CNU/VNU array for up to MAX_IT iterations of PIPE cycles each,
// checks the parity syndrome after every iteration and hands the decoded
// word out over a valid/ready stream.
//
// Optional feature macro: LDPC_EARLY_TERM_EN
//   defined   -> stop at the first iteration whose syndrome is zero
//   undefined -> always run MAX_IT iterations; out_conv reports the final syndrome
module ldpc_iter_ctrl #(
  parameter int DATA_W = 8,
  parameter int R      = 5,
  parameter int C      = 3,
  parameter int D      = 8,
  parameter int MAX_IT = 10,
  parameter int PIPE   = 2,
  parameter int IT_W   = $clog2(MAX_IT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W*D-1:0]     in_llr,
  input  logic [DATA_W*C*R-1:0]   mtx_in,
  output logic [DATA_W*R*D-1:0]   arr_l,
  output logic [DATA_W*C*R-1:0]   arr_mtx,
  output logic                    arr_init,
  output logic                    arr_en,
  input  logic [R*D-1:0]          arr_dec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [R*D-1:0]          out_dec,
  output logic [IT_W-1:0]         out_iter,
  output logic                    out_conv,
  output logic                    busy
);

  localparam int BC_W = (R > 1) ? $clog2(R) : 1;
  localparam int PC_W = (PIPE > 1) ? $clog2(PIPE) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t                state;
  logic [BC_W-1:0]       beat_cnt;
  logic [PC_W-1:0]       pipe_cnt;
  logic [IT_W-1:0]       iter_cnt;
  logic [DATA_W*D-1:0]   llr_buf [R];
  logic [DATA_W*C*R-1:0] mtx_reg;
  logic [C*D-1:0]        syndrome;
  logic                  syn_zero;
  logic                  last_iter;

  // Syndrome bit (i,k) is the XOR over non-null circulants of row i of the
  // hard decision at column j, cyclically shifted by the circulant's shift.
  // The shift is below D, so k+shift < 2D and one conditional subtract
  // replaces the modulo.
  function automatic logic [C*D-1:0] calc_syndrome(
    input logic [R*D-1:0]        dec,
    input logic [DATA_W*C*R-1:0] mtx
  );
    logic [C*D-1:0] syn;
    int sh;
    int idx;
    syn = '0;
    for (int i = 0; i < C; i++) begin
      for (int k = 0; k < D; k++) begin
        for (int j = 0; j < R; j++) begin
          sh = int'(mtx[(i*R+j)*DATA_W +: DATA_W]);
          if (sh < D) begin
            idx = k + sh;
            if (idx >= D) idx = idx - D;
            syn[i*D+k] = syn[i*D+k] ^ dec[j*D+idx];
          end
        end
      end
    end
    return syn;
  endfunction

  // Syndrome of the array's current hard decisions against the latched matrix.
  always_comb begin
    syndrome  = calc_syndrome(arr_dec, mtx_reg);
    syn_zero  = (syndrome == '0);
    last_iter = (iter_cnt == IT_W'(MAX_IT));
  end

  // Stream and array strobes are decoded straight from the state register.
  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign arr_en    = (state == RUN);
  assign arr_init  = (state == RUN) && (iter_cnt == '0) && (pipe_cnt == '0);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign arr_mtx   = mtx_reg;

  for (genvar gj = 0; gj < R; gj++) begin : g_arr_l
    assign arr_l[gj*DATA_W*D +: DATA_W*D] = llr_buf[gj];
  end

  // Main controller: load beats, sequence iterations, check, hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      pipe_cnt <= '0;
      iter_cnt <= '0;
      mtx_reg  <= '0;
      out_dec  <= '0;
      out_iter <= '0;
      out_conv <= 1'b0;
      for (int j = 0; j < R; j++) llr_buf[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            llr_buf[0] <= in_llr;
            mtx_reg    <= mtx_in;
            iter_cnt   <= '0;
            pipe_cnt   <= '0;
            beat_cnt   <= BC_W'(1);
            state      <= (R == 1) ? RUN : LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            llr_buf[beat_cnt] <= in_llr;
            if (beat_cnt == BC_W'(R - 1)) begin
              state <= RUN;
            end else begin
              beat_cnt <= beat_cnt + BC_W'(1);
            end
          end
        end
        RUN: begin
          if (pipe_cnt == PC_W'(PIPE - 1)) begin
            pipe_cnt <= '0;
            iter_cnt <= iter_cnt + IT_W'(1);
            state    <= CHECK;
          end else begin
            pipe_cnt <= pipe_cnt + PC_W'(1);
          end
        end
        CHECK: begin
`ifdef LDPC_EARLY_TERM_EN
          if (syn_zero || last_iter) begin
`else
          if (last_iter) begin
`endif
            out_dec  <= arr_dec;
            out_iter <= iter_cnt;
            out_conv <= syn_zero;
            state    <= OUT;
          end else begin
            state <= RUN;
          end
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
